// File: rtl/btn_event_pkg.sv
// Shared definitions for the push-button event generator.
// Holds the FSM state encoding, default timing constants used by the
// key-scan top and benches, and a small counter-width helper.
package btn_event_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_PRESSED = ST_PRESSED,
    S_LONG    = ST_LONG
  } btn_state_t;

  // 1 ms tick at 50 MHz, 500 ms long-press, 100 ms repeat period.
  localparam int BTN_TICK_DIV_DEF     = 50000;
  localparam int BTN_LONG_TICKS_DEF   = 500;
  localparam int BTN_REPEAT_TICKS_DEF = 100;

  // Event pulses that are always present, registered together.
  typedef struct packed {
    logic press;
    logic rel;
    logic short_click;
    logic long_hold;
  } btn_evt_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Tick prescaler for the button event generator.
// tick_cnt runs 0..TICK_DIV-1 and wraps; tick is high while tick_cnt sits
// on its last value. clear restarts the count so that the first tick lands
// exactly TICK_DIV cycles after the clearing edge.
module btn_tick_gen
  import btn_event_pkg::*;
#(
  parameter int TICK_DIV = BTN_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("btn_tick_gen: TICK_DIV must be at least 2");
  end

  assign tick = (tick_cnt == CNT_LAST);

  // Free-running modulo-TICK_DIV counter, restarted by clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Push-button event generator: turns a debounced button level into
// single-cycle press / release / short-click / long-press pulses plus a
// held level. Optional auto-repeat in the long-press state is enabled by
// defining BTN_AUTO_REPEAT_EN; without it repeat_o is tied low and the
// repeat counter does not exist.
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  S_IDLE     | button released, waiting for a rising level
//  S_PRESSED  | held, long-press threshold not yet reached
//  S_LONG     | held past LONG_TICKS; long_o already issued (repeats here)
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int TICK_DIV     = BTN_TICK_DIV_DEF,
  parameter int LONG_TICKS   = BTN_LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = BTN_REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_state,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam int HW = cnt_width(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

  if (LONG_TICKS < 1) begin : g_bad_long_ticks
    $error("button_event_gen: LONG_TICKS must be at least 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat_ticks
    $error("button_event_gen: REPEAT_TICKS must be at least 1");
  end

  logic          pb_q;
  logic          rise;
  logic          fall;
  logic          tick;
  logic [HW-1:0] hold_cnt;
  btn_state_t    state_q;
  btn_state_t    state_nxt;
  btn_evt_t      evt_q;
  btn_evt_t      evt_nxt;
  logic          held_q;

  assign rise = ~pb_q & pb_state;
  assign fall = pb_q & ~pb_state;

  // Single register stage on the button level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pb_q <= 1'b0;
    end else begin
      pb_q <= pb_state;
    end
  end

  // Prescaler restarts on every press so hold timing is press-relative.
  btn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (rise),
    .tick  (tick)
  );

  // Hold duration in ticks; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || rise) begin
      hold_cnt <= '0;
    end else if ((state_q == S_PRESSED) && tick && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_cnt;
  logic          repeat_nxt;
  logic          repeat_q;

  // Repeat period counter; held at zero outside S_LONG so that the first
  // repeat comes a full REPEAT_TICKS after long_o.
  always_ff @(posedge clk) begin
    if (reset || (state_q != S_LONG)) begin
      rep_cnt <= '0;
    end else if (tick) begin
      if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  // Repeat pulse; a release on the same edge suppresses it.
  always_comb begin
    repeat_nxt = 1'b0;
    if ((state_q == S_LONG) && !fall && tick && (rep_cnt == REP_LAST)) begin
      repeat_nxt = 1'b1;
    end
  end

  // Registered repeat output.
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_nxt;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  // State register and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      evt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      evt_q   <= evt_nxt;
      held_q  <= (state_nxt != S_IDLE);
    end
  end

  // Next-state and event decode; a release always beats the long threshold.
  always_comb begin
    state_nxt = state_q;
    evt_nxt   = '0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          evt_nxt.press = 1'b1;
          state_nxt     = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          evt_nxt.rel         = 1'b1;
          evt_nxt.short_click = 1'b1;
          state_nxt           = S_IDLE;
        end else if (tick && (hold_cnt == HOLD_LAST)) begin
          evt_nxt.long_hold = 1'b1;
          state_nxt         = S_LONG;
        end
      end
      S_LONG: begin
        if (fall) begin
          evt_nxt.rel = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign press_o   = evt_q.press;
  assign release_o = evt_q.rel;
  assign short_o   = evt_q.short_click;
  assign long_o    = evt_q.long_hold;
  assign held_o    = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with TICK_DIV=4, LONG_TICKS=3,
// REPEAT_TICKS=2. Output vector order: {press, release, short, long, repeat, held}.
// Builds with or without BTN_AUTO_REPEAT_EN; repeat expectations follow the macro.
module tb_button_event_gen;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 3;
  localparam int REPEAT_TICKS = 2;

  localparam logic [5:0] O_NONE    = 6'b000000;
  localparam logic [5:0] O_PRESS   = 6'b100001;
  localparam logic [5:0] O_HELD    = 6'b000001;
  localparam logic [5:0] O_SHORT   = 6'b011000;
  localparam logic [5:0] O_REL     = 6'b010000;
  localparam logic [5:0] O_LONG    = 6'b000101;
  localparam logic [5:0] M_PULSES  = 6'b111110;

  logic clk = 1'b0;
  logic reset;
  logic pb_state;
  logic press_o, release_o, short_o, long_o, repeat_o, held_o;

  int n_checks = 0;
  int n_fail   = 0;

  int long_at;
  int long_n;
  int held_bad;
  int rep_q[$];
  int rep_exp[$];
  logic [5:0] acc;

  always #5 clk = ~clk;

  button_event_gen #(
    .TICK_DIV     (TICK_DIV),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pb_state  (pb_state),
    .press_o   (press_o),
    .release_o (release_o),
    .short_o   (short_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o),
    .held_o    (held_o)
  );

  function automatic logic [5:0] outs();
    return {press_o, release_o, short_o, long_o, repeat_o, held_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press for n_cyc samples, logging long/repeat cycle offsets from press_o.
  task automatic hold_press(input int n_cyc);
    long_at  = -1;
    long_n   = 0;
    held_bad = 0;
    rep_q.delete();
    pb_state = 1'b1;
    step();
    check_eq("hold_press", 32'(outs()), 32'(O_PRESS));
    for (int k = 1; k < n_cyc; k++) begin
      step();
      if (long_o) begin
        long_n++;
        if (long_at < 0) long_at = k;
      end
      if (repeat_o) rep_q.push_back(k);
      if (!held_o) held_bad++;
    end
    pb_state = 1'b0;
    step();
    check_eq("hold_release", 32'(outs()), 32'(O_REL));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    pb_state = 1'b0;

    // Reset held three cycles, then quiet idle.
    step();
    check_eq("rst_c1", 32'(outs()), 32'(O_NONE));
    step();
    step();
    check_eq("rst_c3", 32'(outs()), 32'(O_NONE));
    reset = 1'b0;
    acc = '0;
    repeat (20) begin
      step();
      acc |= outs();
    end
    check_eq("idle_quiet", 32'(acc), 32'(O_NONE));

    // Short press: six high samples.
    pb_state = 1'b1;
    step();
    check_eq("short_press", 32'(outs()), 32'(O_PRESS));
    acc = '0;
    held_bad = 0;
    repeat (5) begin
      step();
      acc |= outs() & M_PULSES;
      if (!held_o) held_bad++;
    end
    check_eq("short_no_pulse", 32'(acc), 32'(O_NONE));
    check_eq("short_held", 32'(held_bad), 32'(0));
    pb_state = 1'b0;
    step();
    check_eq("short_release", 32'(outs()), 32'(O_SHORT));
    step();
    check_eq("short_after", 32'(outs()), 32'(O_NONE));
    repeat (5) step();

    // Long hold of 20 cycles.
    hold_press(20);
    check_eq("long_at", 32'(long_at), 32'(12));
    check_eq("long_count", 32'(long_n), 32'(1));
    check_eq("long_held", 32'(held_bad), 32'(0));
    check_eq("long_no_rep", 32'(rep_q.size()), 32'(0));
    repeat (3) step();

    // Hold of 40 cycles: repeats only when the feature is built in.
    rep_exp.delete();
`ifdef BTN_AUTO_REPEAT_EN
    rep_exp.push_back(20);
    rep_exp.push_back(28);
    rep_exp.push_back(36);
`endif
    hold_press(40);
    check_eq("rep_long_at", 32'(long_at), 32'(12));
    check_eq("rep_count", 32'(rep_q.size()), 32'(rep_exp.size()));
    for (int i = 0; i < rep_q.size() && i < rep_exp.size(); i++) begin
      check_eq($sformatf("rep_at_%0d", i), 32'(rep_q[i]), 32'(rep_exp[i]));
    end
    repeat (3) step();

    // Release sampled on the same edge as the third tick.
    pb_state = 1'b1;
    step();
    check_eq("bnd_press", 32'(outs()), 32'(O_PRESS));
    acc = '0;
    repeat (11) begin
      step();
      acc |= outs() & M_PULSES;
    end
    check_eq("bnd_quiet", 32'(acc), 32'(O_NONE));
    pb_state = 1'b0;
    step();
    check_eq("bnd_release", 32'(outs()), 32'(O_SHORT));
    repeat (3) step();

    // Reset in the middle of a long hold.
    pb_state = 1'b1;
    step();
    check_eq("mid_press", 32'(outs()), 32'(O_PRESS));
    repeat (14) step();
    check_eq("mid_long_held", 32'(outs()), 32'(O_HELD));
    reset = 1'b1;
    step();
    check_eq("mid_rst_c1", 32'(outs()), 32'(O_NONE));
    step();
    check_eq("mid_rst_c2", 32'(outs()), 32'(O_NONE));
    reset = 1'b0;
    step();
    check_eq("mid_repress", 32'(outs()), 32'(O_PRESS));
    long_at = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (long_o && long_at < 0) begin
        long_at = k;
        check_eq("mid_long_vec", 32'(outs()), 32'(O_LONG));
      end
    end
    check_eq("mid_long_at", 32'(long_at), 32'(12));
    pb_state = 1'b0;
    step();
    check_eq("mid_release", 32'(outs()), 32'(O_REL));
    step();
    check_eq("mid_after", 32'(outs()), 32'(O_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
